// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an internal word FIFO, with per-frame parity and 1/2 stop bits.
// Words are serialised LSB first, back-to-back while the FIFO holds data; tx is registered.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            tx_valid_i,
  input  logic [DW-1:0]                   tx_data_i,
  output logic                            tx_ready_o,
  input  logic [1:0]                      parity_mode_i,
  input  logic                            stop2_i,
  output logic                            tx,
  output logic                            tx_busy,
  output logic                            tx_done_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o
);
  localparam int BIT    = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W  = (BIT < 2) ? 1 : $clog2(BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W  = $clog2(DW);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(BIT - 1);
  localparam logic [IDX_W-1:0]  DW_LAST  = IDX_W'(DW - 1);
  localparam logic [FCNT_W-1:0] DEPTH    = FCNT_W'(FIFO_DEPTH);

  if (BIT < 2) begin : g_bit_check
    $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (DW < 5 || DW > 9) begin : g_dw_check
    $error("uart_tx_fifo: DW must be within 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // FIFO
  logic [DW-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] count;
  logic              push, pop;
  logic [DW-1:0]     head;

  assign tx_ready_o   = (count < DEPTH);
  assign fifo_count_o = count;
  assign push         = tx_valid_i && tx_ready_o;
  assign head         = mem[rd_ptr];

  // NOTE: storage carries no reset; the count gates every read, so stale entries are never seen.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= tx_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Transmit FSM
  state_t            state_q, state_d;
  logic [DW-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  bit_q, bit_d;
  logic              stop_q, stop_d;
  logic              par_en_q, par_en_d;
  logic              par_q, par_d;
  logic              stop2_q, stop2_d;
  logic              tx_d, done_d;
  logic              bit_end;

  assign bit_end = (cnt_q == BIT_LAST);
  assign tx_busy = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every signal gets a default first so no branch can infer a latch.
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = bit_end ? '0 : cnt_q + 1'b1;
    bit_d    = bit_q;
    stop_d   = stop_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    stop2_d  = stop2_q;
    done_d   = 1'b0;
    pop      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (count != '0) pop = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b1, shift_q[DW-1:1]};
          if (bit_q == DW_LAST) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (count != '0) pop = 1'b1;
            else             state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A pop loads the next frame and freezes its configuration until the following pop.
    if (pop) begin
      state_d  = S_START;
      shift_d  = head;
      cnt_d    = '0;
      par_en_d = (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);
      par_d    = (^head) ^ (parity_mode_i == 2'b10);
      stop2_d  = stop2_i;
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      shift_q   <= '1;
      cnt_q     <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_q     <= 1'b0;
      stop2_q   <= 1'b0;
      tx        <= 1'b1;
      tx_done_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      par_en_q  <= par_en_d;
      par_q     <= par_d;
      stop2_q   <= stop2_d;
      tx        <= tx_d;
      tx_done_o <= done_d;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an internal transmit FIFO, runtime-selectable parity and 1/2 stop bits. It replaces the fixed 8N1 single-byte transmitter: hosts push words through a valid/ready handshake and the block serialises them back-to-back on `tx`. It sits between a bus-side register block or DMA and the serial pin, and shares one clock domain with its host.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz
- `BAUD_RATE`, 115200: line rate in baud
- `DW`, 8: data bits per frame; legal range 5..9
- `FIFO_DEPTH`, 4: FIFO entries; power of two, ≥2
- `clk_i`  input  1  clock; one clock, all logic on its rising edge
- `rst_n_i`  input  1  asynchronous, active-low reset
- `tx_valid_i`  input  1  host offers `tx_data_i`
- `tx_data_i`  input  DW  word to send, LSB transmitted first
- `tx_ready_o`  output  1  FIFO can accept a word (`fifo_count_o < FIFO_DEPTH`)
- `parity_mode_i`  input  2  00 none, 01 even, 10 odd, 11 treated as none
- `stop2_i`  input  1  0 = one stop bit, 1 = two stop bits
- `tx`  output  1  serial line, idle high
- `tx_busy`  output  1  FSM not in IDLE
- `tx_done_o`  output  1  one-cycle pulse on the edge that completes a frame
- `fifo_count_o`  output  $clog2(FIFO_DEPTH+1)  words held in the FIFO

## Operation
- Push: on any edge with `tx_valid_i && tx_ready_o`, write `tx_data_i`. `tx_ready_o` decodes only from registered count, so there is no valid-to-ready path.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when the FIFO is non-empty. On that edge the FSM pops the head word into the shift register and latches `parity_mode_i` and `stop2_i` for the whole frame.
- START (tx=0, one bit) → DATA.
- DATA: tx = shift[0]. Shift right on each bit boundary. After DW bits, go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: tx = XOR of the latched data bits (even), or its inverse (odd).
- STOP: tx=1 for 1 or 2 bits. At the end, pulse `tx_done_o`. If the FIFO is non-empty, pop and go directly to START with no idle cycle; otherwise go to IDLE.
- Illegal or unreachable state → IDLE, with tx=1.
- Push and pop on the same edge leave the count unchanged. Pop never occurs when the count is 0. Push never occurs when the count equals FIFO_DEPTH.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Config input changes mid-frame have no effect until the next pop.

## Timing
- BIT = CLK_FREQ/BAUD_RATE (integer division). Elaboration fails if BIT < 2 or DW is outside 5..9.
- Baud counter clears on the pop edge and at every bit boundary. Every bit, including the final stop bit, lasts exactly BIT cycles.
- Frame length = (1 + DW + P + S)·BIT cycles, where P ∈ {0,1} and S ∈ {1,2}.
- Latency: for a push on edge E0 into an empty FIFO while IDLE, the pop happens on E0+1. `tx` falls and `tx_busy` rises in the cycle after E0+1.
- `tx` and `tx_busy` depend only on registered state and the shift register, with no input-to-output combinational path. `tx` must be glitch-free.
- Reset values: `tx`=1, `tx_busy`=0, `tx_done_o`=0, `tx_ready_o`=1, `fifo_count_o`=0. FSM=IDLE, FIFO empty, shift register all ones.
- Reset asserted mid-frame:
  - All outputs take their reset values immediately, without waiting for a clock.
  - Queued words are discarded.
  - No frame starts after release until a new push.

## Test plan
Bench parameters: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (BIT=10), DW=8, FIFO_DEPTH=4.
- **8N1, single word.** Push 0xA5, parity 00, stop2 0.
  - `tx` is low for 10 cycles from E0+1, then 1,0,1,0,0,1,0,1 for 10 cycles each, then high for 10 cycles.
  - `tx_done_o` pulses once, 100 cycles after the pop. `tx_busy` is high for exactly 100 cycles.
- **Parity and two stop bits.**
  - 0x07 with even parity → parity bit 1. 0x07 with odd parity → parity bit 0.
  - With stop2=1, each frame lasts 120 cycles and its last 20 cycles are high.
- **FIFO full and back-to-back frames.** Hold `tx_valid_i` high for 6 cycles from idle.
  - Exactly 5 words are accepted: the first is popped on E0+1. `fifo_count_o` reads 1,1,2,3,4.
  - `tx_ready_o` is low after the 5th push until the first frame ends.
  - The 5 frames occupy 500 consecutive cycles with no idle gap between them.
- **Reset mid-frame.** Assert `rst_n_i` during the DATA bit 3 with 2 words queued.
  - `tx`=1, `tx_busy`=0, `fifo_count_o`=0 and `tx_ready_o`=1 before the next clock edge.
  - After release, `tx` stays high for 200 cycles while no push occurs.
- **Config change mid-frame.** Change `parity_mode_i` from 00 to 01 during DATA of frame 1 (0x55), with frame 2 (0x55) queued.
  - Frame 1 is 100 cycles long with no parity bit.
  - Frame 2 is 110 cycles long with parity bit 0.
